// File: rtl/mandel_ddr_pkg.sv
// Shared definitions for the DDR port-0 arbiter slice.
//   MCB_CMD_WRITE / MCB_CMD_READ : MCB instruction encodings
//   MCB_BL_W                     : width of an MCB burst-length field (length minus 1)
//   CREDIT_W                     : width of the read-FIFO credit counter
//   arb_state_e                  : arbiter FSM states
//   burst_words()                : burst length field -> number of 32-bit words
package mandel_ddr_pkg;

    localparam logic [2:0] MCB_CMD_WRITE = 3'b000;
    localparam logic [2:0] MCB_CMD_READ  = 3'b001;

    localparam int unsigned MCB_BL_W = 6;
    localparam int unsigned CREDIT_W = MCB_BL_W + 1;

    typedef enum logic [1:0] {
        StWaitCal,
        StArb,
        StCmd
    } arb_state_e;

    // A burst of bl+1 words; needs one extra bit so bl=63 yields 64.
    function automatic logic [MCB_BL_W:0] burst_words(input logic [MCB_BL_W-1:0] bl);
        return {1'b0, bl} + (MCB_BL_W + 1)'(1);
    endfunction

endpackage

// File: rtl/ddr_rd_credit.sv
// Saturating read-credit counter for the MCB read FIFO.
// Tracks how many words of read-FIFO space are not yet claimed by issued read bursts.
//   clk, rst_n   : clock, asynchronous active-low reset (credit returns to Depth)
//   issue_i      : a read command is issued this cycle
//   issue_amt_i  : words claimed by that read (bl+1)
//   pop_i        : one word popped from the read FIFO this cycle
//   need_i       : words a pending read would claim
//   credit_o     : current credit
//   avail_o      : credit_o >= need_i
module ddr_rd_credit
    import mandel_ddr_pkg::*;
#(
    parameter int unsigned Depth = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_i,
    input  logic [CREDIT_W-1:0] issue_amt_i,
    input  logic                pop_i,
    input  logic [CREDIT_W-1:0] need_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                avail_o
);

    localparam logic [CREDIT_W:0] DepthFull = (CREDIT_W + 1)'(Depth);

    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W:0]   sum;

    // Issue is applied before the pop so an issue and a pop in the same cycle at full
    // credit both take effect; only a pop that would push past Depth is dropped.
    always_comb begin
        sum = {1'b0, credit_q};
        if (issue_i) begin
            sum = (sum >= {1'b0, issue_amt_i}) ? sum - {1'b0, issue_amt_i} : '0;
        end
        if (pop_i && (sum < DepthFull)) begin
            sum = sum + (CREDIT_W + 1)'(1);
        end
        credit_d = sum[CREDIT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= DepthFull[CREDIT_W-1:0];
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_o = credit_q;
    assign avail_o  = (credit_q >= need_i);

    // A pop with nothing outstanding means the requester and the MCB disagree.
    a_no_pop_at_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && !issue_i && ({1'b0, credit_q} == DepthFull)));

endmodule

// File: rtl/ddr_port_arbiter.sv
// Arbiter sharing MCB user port 0 between the Mandelbrot burst writer and the VGA
// prefetcher. After calibration it alternates ARB/CMD, issuing at most one command per
// two cycles, gated on write-FIFO fill, command-FIFO space and read-FIFO credit.
// Optional statistics counters: define DDR_ARB_STATS_EN.
//   clk, rst_n              : clock, asynchronous active-low reset
//   mem_calib_done_i        : MCB calibration done (asynchronous, synchronised here)
//   wr_req_i/addr/bl        : write burst request (bl = length minus 1)
//   wr_gnt_o                : one-cycle pulse when the write command is issued
//   rd_req_i/addr/bl        : read burst request
//   rd_urgent_i             : display FIFO below watermark
//   rd_gnt_o                : one-cycle pulse when the read command is issued
//   p0_cmd_full_i           : MCB command FIFO full
//   p0_wr_count_i           : words in MCB write FIFO
//   p0_rd_en_i              : MCB read FIFO pop (display side)
//   p0_cmd_*_o              : MCB command strobe, instruction, burst length, address
//   busy_o                  : high once calibration has been seen
//   stat_*_o                : command / forced-write counters (0 when stats disabled)
module ddr_port_arbiter
    import mandel_ddr_pkg::*;
#(
    parameter int unsigned ADDR_W       = 30,
    parameter int unsigned RD_DEPTH     = 64,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_calib_done_i,
    input  logic                wr_req_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [MCB_BL_W-1:0] wr_bl_i,
    output logic                wr_gnt_o,
    input  logic                rd_req_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    input  logic [MCB_BL_W-1:0] rd_bl_i,
    input  logic                rd_urgent_i,
    output logic                rd_gnt_o,
    input  logic                p0_cmd_full_i,
    input  logic [6:0]          p0_wr_count_i,
    input  logic                p0_rd_en_i,
    output logic                p0_cmd_en_o,
    output logic [2:0]          p0_cmd_instr_o,
    output logic [MCB_BL_W-1:0] p0_cmd_bl_o,
    output logic [ADDR_W-1:0]   p0_cmd_byte_addr_o,
    output logic                busy_o,
    output logic [15:0]         stat_wr_cmds_o,
    output logic [15:0]         stat_rd_cmds_o,
    output logic [15:0]         stat_starve_forced_o
);

    localparam int unsigned         StarveW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0]  StarveMax = StarveW'(STARVE_LIMIT);
    localparam logic [CREDIT_W:0]   RdDepthW  = (CREDIT_W + 1)'(RD_DEPTH);

    // Calibration synchroniser
    logic calib_meta_q, calib_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calib_meta_q <= 1'b0;
            calib_sync_q <= 1'b0;
        end else begin
            calib_meta_q <= mem_calib_done_i;
            calib_sync_q <= calib_meta_q;
        end
    end

    // FSM and registered command outputs
    arb_state_e          state_q;
    logic                busy_q;
    logic                cmd_en_q, wr_gnt_q, rd_gnt_q;
    logic [2:0]          cmd_instr_q;
    logic [MCB_BL_W-1:0] cmd_bl_q;
    logic [ADDR_W-1:0]   cmd_addr_q;
    logic                sel_wr_q;
    logic [MCB_BL_W-1:0] sel_bl_q;
    logic [ADDR_W-1:0]   sel_addr_q;
    logic                last_wr_q;
    logic [StarveW-1:0]  starve_q;

    // Read credit
    logic [CREDIT_W-1:0] rd_credit;
    logic                rd_credit_ok;
    logic                rd_issue;

    assign rd_issue = (state_q == StCmd) && !sel_wr_q;

    ddr_rd_credit #(
        .Depth (RD_DEPTH)
    ) u_rd_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_i     (rd_issue),
        .issue_amt_i (burst_words(sel_bl_q)),
        .pop_i       (p0_rd_en_i),
        .need_i      (burst_words(rd_bl_i)),
        .credit_o    (rd_credit),
        .avail_o     (rd_credit_ok)
    );

    // Eligibility and priority
    logic wr_elig, rd_elig, force_wr, urgent_rd;
    logic pick_wr, pick_rd;

    assign wr_elig   = wr_req_i && !p0_cmd_full_i && (p0_wr_count_i >= burst_words(wr_bl_i));
    assign rd_elig   = rd_req_i && !p0_cmd_full_i && rd_credit_ok;
    assign force_wr  = (starve_q == StarveMax) && wr_elig;
    assign urgent_rd = rd_urgent_i && rd_elig;

    always_comb begin
        pick_wr = 1'b0;
        pick_rd = 1'b0;
        if (force_wr) begin
            pick_wr = 1'b1;
        end else if (urgent_rd) begin
            pick_rd = 1'b1;
        end else if (wr_elig && rd_elig) begin
            // Round-robin: whoever did not win last time
            pick_wr = !last_wr_q;
            pick_rd = last_wr_q;
        end else begin
            pick_wr = wr_elig;
            pick_rd = rd_elig;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitCal;
            busy_q      <= 1'b0;
            cmd_en_q    <= 1'b0;
            wr_gnt_q    <= 1'b0;
            rd_gnt_q    <= 1'b0;
            cmd_instr_q <= MCB_CMD_WRITE;
            cmd_bl_q    <= '0;
            cmd_addr_q  <= '0;
            sel_wr_q    <= 1'b0;
            sel_bl_q    <= '0;
            sel_addr_q  <= '0;
            last_wr_q   <= 1'b0;
            starve_q    <= '0;
        end else begin
            cmd_en_q <= 1'b0;
            wr_gnt_q <= 1'b0;
            rd_gnt_q <= 1'b0;
            unique case (state_q)
                StWaitCal: begin
                    // Calibration is only ever waited for once; a later drop is ignored.
                    if (calib_sync_q) begin
                        state_q <= StArb;
                        busy_q  <= 1'b1;
                    end
                end
                StArb: begin
                    if (pick_wr || pick_rd) begin
                        sel_wr_q   <= pick_wr;
                        sel_bl_q   <= pick_wr ? wr_bl_i : rd_bl_i;
                        sel_addr_q <= pick_wr ? wr_addr_i : rd_addr_i;
                        last_wr_q  <= pick_wr;
                        // A read that won only because it was urgent starves the writer.
                        if (urgent_rd && wr_elig && !force_wr && (starve_q != StarveMax)) begin
                            starve_q <= starve_q + StarveW'(1);
                        end
                        state_q <= StCmd;
                    end
                end
                StCmd: begin
                    // Issue what ARB registered; resources are not re-checked here.
                    cmd_en_q    <= 1'b1;
                    wr_gnt_q    <= sel_wr_q;
                    rd_gnt_q    <= !sel_wr_q;
                    cmd_instr_q <= sel_wr_q ? MCB_CMD_WRITE : MCB_CMD_READ;
                    cmd_bl_q    <= sel_bl_q;
                    cmd_addr_q  <= sel_addr_q;
                    if (sel_wr_q) begin
                        starve_q <= '0;
                    end
                    state_q <= StArb;
                end
                default: state_q <= StWaitCal;
            endcase
        end
    end

    assign p0_cmd_en_o        = cmd_en_q;
    assign wr_gnt_o           = wr_gnt_q;
    assign rd_gnt_o           = rd_gnt_q;
    assign p0_cmd_instr_o     = cmd_instr_q;
    assign p0_cmd_bl_o        = cmd_bl_q;
    assign p0_cmd_byte_addr_o = cmd_addr_q;
    assign busy_o             = busy_q;

    a_credit_bounded : assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, rd_credit} <= RdDepthW));

`ifdef DDR_ARB_STATS_EN
    logic [15:0] stat_wr_q, stat_rd_q, stat_forced_q;
    logic        sel_forced_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_q     <= '0;
            stat_rd_q     <= '0;
            stat_forced_q <= '0;
            sel_forced_q  <= 1'b0;
        end else begin
            if ((state_q == StArb) && (pick_wr || pick_rd)) begin
                sel_forced_q <= force_wr;
            end
            if (state_q == StCmd) begin
                if (sel_wr_q) begin
                    stat_wr_q <= stat_wr_q + 16'd1;
                    if (sel_forced_q) begin
                        stat_forced_q <= stat_forced_q + 16'd1;
                    end
                end else begin
                    stat_rd_q <= stat_rd_q + 16'd1;
                end
            end
        end
    end

    assign stat_wr_cmds_o       = stat_wr_q;
    assign stat_rd_cmds_o       = stat_rd_q;
    assign stat_starve_forced_o = stat_forced_q;
`else
    assign stat_wr_cmds_o       = '0;
    assign stat_rd_cmds_o       = '0;
    assign stat_starve_forced_o = '0;
`endif

endmodule
